sbox_bram_port_sched: RTL and testbench



---
 rtl/sbox_bram_port_sched.sv | 133 +++++++++++++
 tb/tb_sbox_bram_port_sched.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_bram_port_sched.sv
// Schedules masked S-box lookups from the state (S) and key-schedule (K)
// requesters onto one dual-port S-box BRAM. Each lookup drives port A and
// port B in the same cycle. A LAT-deep tag pipeline follows the BRAM read
// latency and returns both share bytes in issue order, tagged by source.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   s_req_* / k_req_*            valid/ready request channels with A/B addresses
//   bram_addra/addrb/en/rst      BRAM control (en drives ENA/ENB/REGCE)
//   bram_doa/dob                 BRAM registered read data
//   rsp_valid/ready/src/doa/dob  response channel (src: 0 = S, 1 = K)
//   busy                         request pending or lookup in flight
module sbox_bram_port_sched #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req_valid,
  output logic              s_req_ready,
  input  logic [ADDR_W-1:0] s_addr_a,
  input  logic [ADDR_W-1:0] s_addr_b,
  input  logic              k_req_valid,
  output logic              k_req_ready,
  input  logic [ADDR_W-1:0] k_addr_a,
  input  logic [ADDR_W-1:0] k_addr_b,
  output logic [ADDR_W-1:0] bram_addra,
  output logic [ADDR_W-1:0] bram_addrb,
  output logic              bram_en,
  output logic              bram_rst,
  input  logic [DATA_W-1:0] bram_doa,
  input  logic [DATA_W-1:0] bram_dob,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_src,
  output logic [DATA_W-1:0] rsp_doa,
  output logic [DATA_W-1:0] rsp_dob,
  output logic              busy
);

  // Tag pipeline: one {valid, src} pair per BRAM latency stage.
  logic [LAT-1:0]    vld_q, vld_d;
  logic [LAT-1:0]    src_q, src_d;
  // 1 = K was granted last, so S wins the next contention.
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;

  logic tail_valid;
  logic stall;
  logic grant_s;
  logic grant_k;

  assign tail_valid = vld_q[LAT-1];
  // A held response freezes the BRAM output register and the whole pipeline.
  assign stall      = tail_valid & ~rsp_ready;

  // Round-robin arbitration; no grant while in reset or stalled.
  always_comb begin
    grant_s = 1'b0;
    grant_k = 1'b0;
    if (!rst && !stall) begin
      if (s_req_valid && k_req_valid) begin
        if (last_grant_q) grant_s = 1'b1;
        else              grant_k = 1'b1;
      end else if (s_req_valid) begin
        grant_s = 1'b1;
      end else if (k_req_valid) begin
        grant_k = 1'b1;
      end
    end
  end

  always_comb begin
    vld_d        = vld_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    if (!stall) begin
      for (int i = LAT - 1; i > 0; i--) begin
        vld_d[i] = vld_q[i-1];
        src_d[i] = src_q[i-1];
      end
      vld_d[0] = grant_s | grant_k;
      src_d[0] = grant_k;
    end
    if (grant_s) begin
      addr_a_d     = s_addr_a;
      addr_b_d     = s_addr_b;
      last_grant_d = 1'b0;
    end else if (grant_k) begin
      addr_a_d     = k_addr_a;
      addr_b_d     = k_addr_b;
      last_grant_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      src_q        <= '0;
      last_grant_q <= 1'b1;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
    end else begin
      vld_q        <= vld_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
    end
  end

  // Addresses come straight from the granted requester; on idle cycles the
  // hold registers keep the BRAM address lines from toggling.
  assign bram_addra  = addr_a_d;
  assign bram_addrb  = addr_b_d;
  assign bram_en     = ~stall;
  assign bram_rst    = rst;

  assign s_req_ready = grant_s;
  assign k_req_ready = grant_k;

  assign rsp_valid   = tail_valid;
  assign rsp_src     = src_q[LAT-1];
  assign rsp_doa     = bram_doa;
  assign rsp_dob     = bram_dob;

  assign busy        = ~rst & (s_req_valid | k_req_valid | (|vld_q));

endmodule

// File: tb/tb_sbox_bram_port_sched.sv
module tb_sbox_bram_port_sched;

  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_req_valid, s_req_ready, k_req_valid, k_req_ready;
  logic [AW-1:0] s_addr_a, s_addr_b, k_addr_a, k_addr_b;
  logic [AW-1:0] bram_addra, bram_addrb;
  logic          bram_en, bram_rst;
  logic [DW-1:0] bram_doa, bram_dob;
  logic          rsp_valid, rsp_ready, rsp_src, busy;
  logic [DW-1:0] rsp_doa, rsp_dob;

  typedef struct packed {
    logic          src;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
  } look_t;

  look_t         exp_q[$];
  logic          last_k;
  logic [AW-1:0] hold_a, hold_b;
  int            checks = 0;
  int            errors = 0;
  int            n_req  = 0;
  int            n_rsp  = 0;

  sbox_bram_port_sched #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_addr_a(s_addr_a), .s_addr_b(s_addr_b),
    .k_req_valid(k_req_valid), .k_req_ready(k_req_ready),
    .k_addr_a(k_addr_a), .k_addr_b(k_addr_b),
    .bram_addra(bram_addra), .bram_addrb(bram_addrb),
    .bram_en(bram_en), .bram_rst(bram_rst),
    .bram_doa(bram_doa), .bram_dob(bram_dob),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_src(rsp_src),
    .rsp_doa(rsp_doa), .rsp_dob(rsp_dob),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // S-box table contents: any fixed address-dependent byte will do.
  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    return a[7:0] ^ {a[9:8], a[9:4]} ^ 8'h63;
  endfunction

  // BRAM model: LAT register stages, all gated by EN, cleared by RST.
  logic [DW-1:0] pa[LAT];
  logic [DW-1:0] pb[LAT];
  always @(posedge clk) begin
    if (bram_rst) begin
      for (int i = 0; i < LAT; i++) begin
        pa[i] <= '0;
        pb[i] <= '0;
      end
    end else if (bram_en) begin
      pa[0] <= rom(bram_addra);
      pb[0] <= rom(bram_addrb);
      for (int i = 1; i < LAT; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
  end
  assign bram_doa = pa[LAT-1];
  assign bram_dob = pb[LAT-1];

  task automatic reset_model();
    exp_q.delete();
    last_k = 1'b1;
    hold_a = '0;
    hold_b = '0;
  endtask

  // One clock cycle with the reference scoreboard applied at the falling edge:
  // predicted grant, enable and addresses; in-order response data.
  task automatic step();
    logic          stl, ex_s, ex_k;
    logic [AW-1:0] ea, eb;
    look_t         e;
    @(negedge clk);
    if (rst) begin
      reset_model();
    end else begin
      stl  = rsp_valid && !rsp_ready;
      ex_s = 1'b0;
      ex_k = 1'b0;
      if (!stl) begin
        if (s_req_valid && k_req_valid) begin
          ex_s = last_k;
          ex_k = !last_k;
        end else begin
          ex_s = s_req_valid;
          ex_k = k_req_valid;
        end
      end
      ea = ex_s ? s_addr_a : (ex_k ? k_addr_a : hold_a);
      eb = ex_s ? s_addr_b : (ex_k ? k_addr_b : hold_b);
      checks++;
      if ({s_req_ready, k_req_ready} !== {ex_s, ex_k}) begin
        errors++;
        $display("FAIL grant got s=%0b k=%0b want s=%0b k=%0b at %0t",
                 s_req_ready, k_req_ready, ex_s, ex_k, $time);
      end
      checks++;
      if (bram_en !== !stl) begin
        errors++;
        $display("FAIL bram_en got %0b want %0b at %0t", bram_en, !stl, $time);
      end
      checks++;
      if ({bram_addra, bram_addrb} !== {ea, eb}) begin
        errors++;
        $display("FAIL bram_addr got %h/%h want %h/%h at %0t",
                 bram_addra, bram_addrb, ea, eb, $time);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_extra got src=%0b want no response at %0t", rsp_src, $time);
        end else begin
          e = exp_q.pop_front();
          n_rsp++;
          if ({rsp_src, rsp_doa, rsp_dob} !== {e.src, rom(e.a), rom(e.b)}) begin
            errors++;
            $display("FAIL rsp_data got src=%0b %h/%h want src=%0b %h/%h at %0t",
                     rsp_src, rsp_doa, rsp_dob, e.src, rom(e.a), rom(e.b), $time);
          end
        end
      end
      if (ex_s || ex_k) begin
        last_k = ex_k;
        hold_a = ea;
        hold_b = eb;
        exp_q.push_back('{src: ex_k, a: ea, b: eb});
        n_req++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s_req_valid = 1'b0;
    k_req_valid = 1'b0;
    s_addr_a = '0; s_addr_b = '0; k_addr_a = '0; k_addr_b = '0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    idle_inputs();
    rsp_ready = 1'b1;
    n = 0;
    #1;
    while (busy && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got busy=%0b pending=%0d want 0/0", name, busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_req_valid = 1'b1;
    k_req_valid = 1'b1;
    s_addr_a = 10'h3ff; s_addr_b = 10'h155; k_addr_a = 10'h2aa; k_addr_b = 10'h0f0;
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, s_req_ready, k_req_ready, busy, rsp_src} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outs got v=%0b sr=%0b kr=%0b busy=%0b src=%0b want all 0",
               rsp_valid, s_req_ready, k_req_ready, busy, rsp_src);
    end
    checks++;
    if ({bram_addra, bram_addrb} !== '0 || bram_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_bram got addr=%h/%h rst=%0b want 000/000 1",
               bram_addra, bram_addrb, bram_rst);
    end
    apply_reset();
  endtask

  task automatic test_single();
    s_addr_a = 10'h005;
    s_addr_b = 10'h205;
    s_req_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    step();
    s_req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_early got rsp_valid=%0b want 0", rsp_valid);
      end
      step();
    end
    #1;
    checks++;
    if ({rsp_valid, rsp_src, rsp_doa, rsp_dob} !== {2'b10, rom(10'h005), rom(10'h205)}) begin
      errors++;
      $display("FAIL single_rsp got v=%0b src=%0b %h/%h want 1 0 %h/%h",
               rsp_valid, rsp_src, rsp_doa, rsp_dob, rom(10'h005), rom(10'h205));
    end
    step();
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%0b rsp_valid=%0b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    int idx[$];
    int srcs[$];
    apply_reset();
    s_req_valid = 1'b1; k_req_valid = 1'b1;
    s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
    k_addr_a = AW'($urandom); k_addr_b = AW'($urandom);
    for (int c = 0; c < 6 + LAT + 3; c++) begin
      if (c == 6) begin
        s_req_valid = 1'b0;
        k_req_valid = 1'b0;
      end
      #1;
      if (c < 6) begin
        checks++;
        if ({s_req_ready, k_req_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_grant cycle %0d got s=%0b k=%0b want alternate S first",
                   c, s_req_ready, k_req_ready);
        end
      end
      if (rsp_valid) begin
        idx.push_back(c);
        srcs.push_back(int'(rsp_src));
      end
      step();
      if (c < 6 && c % 2 == 0) begin
        s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
      end else if (c < 6) begin
        k_addr_a = AW'($urandom); k_addr_b = AW'($urandom);
      end
    end
    checks++;
    if (idx.size() != 6) begin
      errors++;
      $display("FAIL rr_count got %0d responses want 6", idx.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (idx[k] != k + LAT || srcs[k] != k % 2) begin
          errors++;
          $display("FAIL rr_order resp %0d got cycle %0d src %0d want cycle %0d src %0d",
                   k, idx[k], srcs[k], k + LAT, k % 2);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic          s0;
    logic [DW-1:0] a0, b0;
    int            n;
    rsp_ready = 1'b0;
    s_req_valid = 1'b1;
    s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
    n = 0;
    #1;
    while (!rsp_valid && n < 10) begin
      step();
      if (s_req_valid) begin
        s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
      end
      n++;
      #1;
    end
    k_req_valid = 1'b1;
    k_addr_a = AW'($urandom); k_addr_b = AW'($urandom);
    #1;
    s0 = rsp_src; a0 = rsp_doa; b0 = rsp_dob;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (bram_en !== 1'b0 || s_req_ready !== 1'b0 || k_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_ctrl got en=%0b sr=%0b kr=%0b want 0 0 0",
                 bram_en, s_req_ready, k_req_ready);
      end
      checks++;
      if ({rsp_valid, rsp_src, rsp_doa, rsp_dob} !== {1'b1, s0, a0, b0}) begin
        errors++;
        $display("FAIL stall_hold got v=%0b src=%0b %h/%h want 1 %0b %h/%h",
                 rsp_valid, rsp_src, rsp_doa, rsp_dob, s0, a0, b0);
      end
      step();
      #1;
    end
    drain("stall");
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      s_req_valid = 1'b1;
      s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
      #1;
      step();
    end
    s_req_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre got rsp_valid=%0b want 1", rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drop got rsp_valid=%0b busy=%0b want 0 0", rsp_valid, busy);
    end
    rst = 1'b0;
    reset_model();
    for (int c = 0; c < LAT + 2; c++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_quiet got rsp_valid=%0b want 0 cycle %0d", rsp_valid, c);
      end
    end
    s_req_valid = 1'b1;
    s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
    #1;
    step();
    s_req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_new got rsp_valid=%0b want 1", rsp_valid);
    end
    drain("rstmid");
  endtask

  task automatic test_k_only();
    logic [AW-1:0] la, lb;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      k_req_valid = 1'b1;
      k_addr_a = AW'($urandom); k_addr_b = AW'($urandom);
      #1;
      checks++;
      if (k_req_ready !== 1'b1 || s_req_ready !== 1'b0 ||
          {bram_addra, bram_addrb} !== {k_addr_a, k_addr_b}) begin
        errors++;
        $display("FAIL konly_issue got kr=%0b sr=%0b addr=%h/%h want 1 0 %h/%h",
                 k_req_ready, s_req_ready, bram_addra, bram_addrb, k_addr_a, k_addr_b);
      end
      step();
    end
    la = k_addr_a; lb = k_addr_b;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({bram_addra, bram_addrb} !== {la, lb}) begin
        errors++;
        $display("FAIL konly_hold got %h/%h want %h/%h", bram_addra, bram_addrb, la, lb);
      end
      step();
    end
    drain("konly");
  endtask

  task automatic test_simul();
    int r0, q0;
    r0 = n_rsp; q0 = n_req;
    rsp_ready = 1'b1;
    s_req_valid = 1'b1;
    s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
    #1;
    step();
    s_req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    s_req_valid = 1'b1;
    s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || s_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_both got rsp_valid=%0b s_ready=%0b want 1 1", rsp_valid, s_req_ready);
    end
    step();
    s_req_valid = 1'b0;
    drain("simul");
    checks++;
    if (n_req - q0 != 2 || n_rsp - r0 != 2) begin
      errors++;
      $display("FAIL simul_count got req=%0d rsp=%0d want 2 2", n_req - q0, n_rsp - r0);
    end
  endtask

  task automatic test_random();
    logic s_fire, k_fire;
    s_fire = 1'b1; k_fire = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!s_req_valid || s_fire) begin
        s_req_valid = $urandom_range(0, 1) == 1;
        s_addr_a = AW'($urandom); s_addr_b = AW'($urandom);
      end
      if (!k_req_valid || k_fire) begin
        k_req_valid = $urandom_range(0, 1) == 1;
        k_addr_a = AW'($urandom); k_addr_b = AW'($urandom);
      end
      #1;
      s_fire = s_req_valid && s_req_ready;
      k_fire = k_req_valid && k_req_ready;
      step();
    end
    drain("random");
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_k_only();
    test_simul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
